// File: rtl/coin_seq_pkg.sv
// coin_seq_pkg: shared types and constants for the coin sequencer.
// Holds the sequencer state encoding, coin id names, the program terminator
// word and the geometry of the per-denomination instruction ROMs.
package coin_seq_pkg;

    // Denomination count and pending-counter width defaults.
    localparam int NUM_COINS_DEF = 4;
    localparam int CNT_W_DEF     = 2;
    localparam int COIN_W        = 2;

    // Instruction ROM geometry: eight 19-bit words per coin.
    localparam int ROM_DEPTH = 8;
    localparam int ROM_AW    = 3;
    localparam int INSTR_W   = 19;

    // Word that terminates a program (also used as the address-0 header).
    localparam logic [INSTR_W-1:0] END_WORD_DEF = 19'h7f000;

    // Address 0 holds the header, so programs start at 1 and end at 7.
    localparam logic [ROM_AW-1:0] ROM_FIRST_ADDR = 3'd1;
    localparam logic [ROM_AW-1:0] ROM_LAST_ADDR  = 3'd7;

    // Coin ids as seen on coin_req bits, rom_sel and done_coin.
    localparam logic [COIN_W-1:0] COIN_5   = 2'd0;
    localparam logic [COIN_W-1:0] COIN_10  = 2'd1;
    localparam logic [COIN_W-1:0] COIN_25  = 2'd2;
    localparam logic [COIN_W-1:0] COIN_100 = 2'd3;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/coin_rr_arbiter.sv
// coin_rr_arbiter: picks one pending coin out of a request vector.
// With COIN_SEQ_RR_EN defined the search starts at a rotating pointer that
// moves to (last grant + 1) whenever 'advance' is high; N must be a power of
// two so the pointer wraps naturally. Without the macro the highest requesting
// id always wins and no state is kept.
module coin_rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
`ifdef COIN_SEQ_RR_EN
    input  logic           clk,
    input  logic           reset,
    input  logic           advance,
`endif
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           any_req
);

`ifdef COIN_SEQ_RR_EN
    logic [IDW-1:0] ptr;
    logic [N-1:0]   rot;
    logic [IDW-1:0] off;

    // Rotate requests so the pointer lands on bit 0, take the lowest set bit.
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IDW'(k);
            end
        end
        gnt_id = ptr + off;
    end

    // Move the priority pointer just past the coin that was granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= gnt_id + 1'b1;
        end
    end
`else
    // Fixed priority: the highest requesting coin id wins.
    always_comb begin
        gnt_id = '0;
        for (int k = 0; k < N; k++) begin
            if (req[k]) begin
                gnt_id = IDW'(k);
            end
        end
    end
`endif

    // One-hot grant derived from the encoded winner.
    always_comb begin
        any_req = |req;
        gnt     = any_req ? (N'(1) << gnt_id) : '0;
    end

endmodule

// File: rtl/coin_seq_ctrl.sv
// coin_seq_ctrl: turns queued coin-insert events into instruction streams for
// the vending-machine CPU. Each coin's ROM is walked from address 1 until the
// terminator word or address 7, one word per valid/ready handshake.
// Build option: COIN_SEQ_RR_EN selects round-robin arbitration between
// pending coins; otherwise the highest coin id is served first.
module coin_seq_ctrl
    import coin_seq_pkg::*;
#(
    parameter int                 NUM_COINS = NUM_COINS_DEF,
    parameter int                 CNT_W     = CNT_W_DEF,
    parameter logic [INSTR_W-1:0] END_WORD  = END_WORD_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_COINS-1:0] coin_req,
    output logic [COIN_W-1:0]    rom_sel,
    output logic [ROM_AW-1:0]    rom_addr,
    input  logic [INSTR_W-1:0]   rom_dout,
    output logic [INSTR_W-1:0]   instr,
    output logic                 instr_valid,
    input  logic                 cpu_ready,
    output logic                 busy,
    output logic                 prog_done,
    output logic [COIN_W-1:0]    done_coin,
    output logic [NUM_COINS-1:0] coin_overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    seq_state_t               state;
    logic [COIN_W-1:0]        cur_coin;
    logic [CNT_W-1:0]         pend [NUM_COINS];
    logic [NUM_COINS-1:0]     pend_nz;
    logic [NUM_COINS-1:0]     gnt;
    logic [NUM_COINS-1:0]     gnt_fire;
    logic [COIN_W-1:0]        gnt_id;
    logic                     any_req;
    logic                     grant_fire;

    // Which coins have work waiting, and whether a grant happens this cycle.
    always_comb begin
        for (int i = 0; i < NUM_COINS; i++) begin
            pend_nz[i] = (pend[i] != '0);
        end
        grant_fire = (state == IDLE) && any_req;
        gnt_fire   = grant_fire ? gnt : '0;
    end

    coin_rr_arbiter #(
        .N   (NUM_COINS),
        .IDW (COIN_W)
    ) u_arb (
`ifdef COIN_SEQ_RR_EN
        .clk     (clk),
        .reset   (reset),
        .advance (grant_fire),
`endif
        .req     (pend_nz),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .any_req (any_req)
    );

    // Per-coin saturating pending counters; a dropped insert flags overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_COINS; i++) begin
                pend[i] <= '0;
            end
            coin_overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_COINS; i++) begin
                coin_overflow[i] <= 1'b0;
                if (coin_req[i] && !gnt_fire[i]) begin
                    if (pend[i] == CNT_MAX) begin
                        coin_overflow[i] <= 1'b1;
                    end else begin
                        pend[i] <= pend[i] + 1'b1;
                    end
                end else if (!coin_req[i] && gnt_fire[i]) begin
                    pend[i] <= pend[i] - 1'b1;
                end
            end
        end
    end

    // Sequencer: grant a coin, fetch each ROM word, hand it to the CPU, finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cur_coin    <= '0;
            rom_sel     <= '0;
            rom_addr    <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            prog_done   <= 1'b0;
            done_coin   <= '0;
        end else begin
            prog_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cur_coin <= gnt_id;
                        rom_sel  <= gnt_id;
                        rom_addr <= ROM_FIRST_ADDR;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (rom_dout == END_WORD) begin
                        prog_done <= 1'b1;
                        done_coin <= cur_coin;
                        state     <= DONE;
                    end else begin
                        instr       <= rom_dout;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cpu_ready) begin
                        instr_valid <= 1'b0;
                        if (rom_addr == ROM_LAST_ADDR) begin
                            prog_done <= 1'b1;
                            done_coin <= cur_coin;
                            state     <= DONE;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    instr_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_seq_ctrl.sv
// tb_coin_seq_ctrl: self-checking bench for coin_seq_ctrl.
// The ROMs live in the bench; expected instruction streams are derived from
// the ROM contents by the program rules (start at address 1, stop at the
// terminator or after address 7), and coin order from the arbitration rule.
module tb_coin_seq_ctrl;
    import coin_seq_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  coin_req;
    logic [1:0]  rom_sel;
    logic [2:0]  rom_addr;
    logic [18:0] rom_dout;
    logic [18:0] instr;
    logic        instr_valid;
    logic        cpu_ready;
    logic        busy;
    logic        prog_done;
    logic [1:0]  done_coin;
    logic [3:0]  coin_overflow;

    logic [18:0] rom [4][8];
    logic [18:0] got_w[$];
    int          got_done[$];
    int          done_cyc[$];
    int          ovf_cyc[$];
    logic [18:0] exp_w[$];
    logic        addr0_seen;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    coin_seq_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .coin_req      (coin_req),
        .rom_sel       (rom_sel),
        .rom_addr      (rom_addr),
        .rom_dout      (rom_dout),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .cpu_ready     (cpu_ready),
        .busy          (busy),
        .prog_done     (prog_done),
        .done_coin     (done_coin),
        .coin_overflow (coin_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational ROM bank in front of the DUT.
    always_comb rom_dout = rom[rom_sel][rom_addr];

    always @(posedge clk) cyc++;

    // Observe accepted words, completions and overflow pulses mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (instr_valid && cpu_ready) got_w.push_back(instr);
            if (prog_done) begin
                got_done.push_back(int'(done_coin));
                done_cyc.push_back(cyc);
            end
            if (coin_overflow[1]) ovf_cyc.push_back(cyc);
            if (busy && rom_addr == 3'd0) addr0_seen = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        got_w.delete();
        got_done.delete();
        done_cyc.delete();
        ovf_cyc.delete();
        exp_w.delete();
        addr0_seen = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        coin_req = '0;
        tick();
        tick();
        reset = 1'b0;
        clear_obs();
    endtask

    // Reference: words a coin's program issues, appended to exp_w.
    task automatic model_append(input int c);
        for (int a = 1; a < 8; a++) begin
            if (rom[c][a] == END_WORD_DEF) break;
            exp_w.push_back(rom[c][a]);
        end
    endtask

    task automatic load_spec_rom();
        rom[3][0] = 19'h7f000; rom[3][1] = 19'h72006; rom[3][2] = 19'h73004;
        rom[3][3] = 19'h52230; rom[3][4] = 19'h32230; rom[3][5] = 19'h04240;
        rom[3][6] = 19'h7f000; rom[3][7] = 19'h12345;
    endtask

    function automatic logic [18:0] rand_word();
        logic [18:0] w;
        w = 19'($urandom);
        if (w == END_WORD_DEF) w = w ^ 19'h1;
        return w;
    endfunction

    task automatic wait_dones(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (got_done.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        coin_req = '1;
        cpu_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %0b expected 0", instr_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (prog_done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %0b expected 0", prog_done); end
        n_cmp++; if (instr !== 19'h0) begin n_err++; $display("[TB] FAIL reset_instr: got %0h expected 0", instr); end
        n_cmp++; if (rom_addr !== 3'd0) begin n_err++; $display("[TB] FAIL reset_addr: got %0d expected 0", rom_addr); end
        n_cmp++; if (rom_sel !== 2'd0) begin n_err++; $display("[TB] FAIL reset_sel: got %0d expected 0", rom_sel); end
        n_cmp++; if (done_coin !== 2'd0) begin n_err++; $display("[TB] FAIL reset_done_coin: got %0d expected 0", done_coin); end
        n_cmp++; if (coin_overflow !== 4'h0) begin n_err++; $display("[TB] FAIL reset_ovf: got %0h expected 0", coin_overflow); end
        coin_req = '0;
        reset = 1'b0;
        clear_obs();
        begin
            bit went_busy;
            went_busy = 1'b0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (busy) went_busy = 1'b1;
            end
            n_cmp++; if (went_busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_counters_clear: got busy %0b expected 0", went_busy); end
        end
    endtask

    task automatic test_single_program();
        int p;
        bit ok;
        do_reset();
        load_spec_rom();
        cpu_ready = 1'b1;
        model_append(3);
        coin_req = 4'b1000;
        p = cyc;
        tick();
        coin_req = '0;
        wait_dones(1, 60, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL single_timeout: got %0d dones expected 1", got_done.size()); end
        tick();
        n_cmp++; if (got_w.size() !== exp_w.size()) begin n_err++; $display("[TB] FAIL single_count: got %0d expected %0d", got_w.size(), exp_w.size()); end
        for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
            n_cmp++; if (got_w[k] !== exp_w[k]) begin n_err++; $display("[TB] FAIL single_word%0d: got %0h expected %0h", k, got_w[k], exp_w[k]); end
        end
        if (ok) begin
            n_cmp++; if (got_done[0] !== int'(COIN_100)) begin n_err++; $display("[TB] FAIL single_coin: got %0d expected 3", got_done[0]); end
            n_cmp++; if (done_cyc[0] !== p + 3 + 2 * exp_w.size()) begin n_err++; $display("[TB] FAIL single_timing: got %0d expected %0d", done_cyc[0] - p, 3 + 2 * exp_w.size()); end
        end
        n_cmp++; if (addr0_seen !== 1'b0) begin n_err++; $display("[TB] FAIL single_addr0: got %0b expected 0", addr0_seen); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL single_idle_after: got %0b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        bit found;
        bit ok;
        do_reset();
        load_spec_rom();
        cpu_ready = 1'b1;
        model_append(3);
        coin_req = 4'b1000;
        tick();
        coin_req = '0;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (instr_valid && instr == 19'h73004) found = 1'b1;
            else tick();
        end
        n_cmp++; if (!found) begin n_err++; $display("[TB] FAIL bp_reach: got %0b expected 1", found); end
        if (found) begin
            cpu_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick();
                n_cmp++; if (instr_valid !== 1'b1 || instr !== 19'h73004) begin n_err++; $display("[TB] FAIL bp_hold%0d: got %0b/%0h expected 1/73004", k, instr_valid, instr); end
            end
            cpu_ready = 1'b1;
            tick();
            n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bp_release: got %0b expected 0", instr_valid); end
        end
        wait_dones(1, 60, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL bp_timeout: got %0d dones expected 1", got_done.size()); end
        n_cmp++; if (got_w.size() !== exp_w.size()) begin n_err++; $display("[TB] FAIL bp_count: got %0d expected %0d", got_w.size(), exp_w.size()); end
        for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
            n_cmp++; if (got_w[k] !== exp_w[k]) begin n_err++; $display("[TB] FAIL bp_word%0d: got %0h expected %0h", k, got_w[k], exp_w[k]); end
        end
    endtask

    task automatic test_arbitration();
        int exp_order[2];
        bit ok;
        do_reset();
        for (int a = 0; a < 8; a++) begin
            rom[0][a] = END_WORD_DEF;
            rom[3][a] = END_WORD_DEF;
        end
        rom[0][1] = 19'h11111;
        rom[3][1] = 19'h33333;
        rom[3][2] = 19'h33334;
`ifdef COIN_SEQ_RR_EN
        exp_order[0] = 0; exp_order[1] = 3;
`else
        exp_order[0] = 3; exp_order[1] = 0;
`endif
        model_append(exp_order[0]);
        model_append(exp_order[1]);
        cpu_ready = 1'b1;
        coin_req = 4'b1001;
        tick();
        coin_req = '0;
        wait_dones(2, 80, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL arb_timeout: got %0d dones expected 2", got_done.size()); end
        for (int k = 0; k < 2 && k < got_done.size(); k++) begin
            n_cmp++; if (got_done[k] !== exp_order[k]) begin n_err++; $display("[TB] FAIL arb_order%0d: got %0d expected %0d", k, got_done[k], exp_order[k]); end
        end
        n_cmp++; if (got_w.size() !== exp_w.size()) begin n_err++; $display("[TB] FAIL arb_count: got %0d expected %0d", got_w.size(), exp_w.size()); end
        for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
            n_cmp++; if (got_w[k] !== exp_w[k]) begin n_err++; $display("[TB] FAIL arb_word%0d: got %0h expected %0h", k, got_w[k], exp_w[k]); end
        end
    endtask

    task automatic test_overflow();
        int pulse_cyc[5];
        bit ok;
        do_reset();
        for (int a = 0; a < 8; a++) begin
            rom[3][a] = rand_word();
            rom[1][a] = END_WORD_DEF;
        end
        rom[1][1] = 19'h10001;
        rom[1][2] = 19'h10002;
        model_append(3);
        for (int k = 0; k < 3; k++) model_append(1);
        cpu_ready = 1'b0;
        coin_req = 4'b1000;
        tick();
        coin_req = '0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            coin_req = 4'b0010;
            pulse_cyc[k] = cyc;
            tick();
            coin_req = '0;
            tick();
        end
        cpu_ready = 1'b1;
        wait_dones(4, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL ovf_timeout: got %0d dones expected 4", got_done.size()); end
        repeat (8) tick();
        n_cmp++; if (ovf_cyc.size() !== 2) begin n_err++; $display("[TB] FAIL ovf_pulses: got %0d expected 2", ovf_cyc.size()); end
        for (int k = 0; k < 2 && k < ovf_cyc.size(); k++) begin
            n_cmp++; if (ovf_cyc[k] !== pulse_cyc[k + 3] + 1) begin n_err++; $display("[TB] FAIL ovf_when%0d: got %0d expected %0d", k, ovf_cyc[k], pulse_cyc[k + 3] + 1); end
        end
        n_cmp++; if (got_done.size() !== 4) begin n_err++; $display("[TB] FAIL ovf_programs: got %0d expected 4", got_done.size()); end
        for (int k = 0; k < 4 && k < got_done.size(); k++) begin
            n_cmp++; if (got_done[k] !== (k == 0 ? 3 : 1)) begin n_err++; $display("[TB] FAIL ovf_coin%0d: got %0d expected %0d", k, got_done[k], (k == 0 ? 3 : 1)); end
        end
        n_cmp++; if (got_w.size() !== exp_w.size()) begin n_err++; $display("[TB] FAIL ovf_count: got %0d expected %0d", got_w.size(), exp_w.size()); end
        for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
            n_cmp++; if (got_w[k] !== exp_w[k]) begin n_err++; $display("[TB] FAIL ovf_word%0d: got %0h expected %0h", k, got_w[k], exp_w[k]); end
        end
    endtask

    task automatic test_no_end();
        bit ok;
        do_reset();
        for (int a = 0; a < 8; a++) rom[2][a] = rand_word();
        model_append(2);
        cpu_ready = 1'b1;
        coin_req = 4'b0100;
        tick();
        coin_req = '0;
        wait_dones(1, 60, ok);
        n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL noend_timeout: got %0d dones expected 1", got_done.size()); end
        tick();
        n_cmp++; if (got_w.size() !== 7) begin n_err++; $display("[TB] FAIL noend_count: got %0d expected 7", got_w.size()); end
        for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
            n_cmp++; if (got_w[k] !== exp_w[k]) begin n_err++; $display("[TB] FAIL noend_word%0d: got %0h expected %0h", k, got_w[k], exp_w[k]); end
        end
        if (ok) begin
            n_cmp++; if (got_done[0] !== int'(COIN_25)) begin n_err++; $display("[TB] FAIL noend_coin: got %0d expected 2", got_done[0]); end
        end
        n_cmp++; if (rom_addr !== 3'd7) begin n_err++; $display("[TB] FAIL noend_addr: got %0d expected 7", rom_addr); end
        n_cmp++; if (addr0_seen !== 1'b0) begin n_err++; $display("[TB] FAIL noend_addr0: got %0b expected 0", addr0_seen); end
    endtask

    task automatic test_reset_mid();
        bit found;
        bit went_busy;
        do_reset();
        load_spec_rom();
        cpu_ready = 1'b0;
        coin_req = 4'b1010;
        tick();
        coin_req = '0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (instr_valid) found = 1'b1;
            else tick();
        end
        n_cmp++; if (!found) begin n_err++; $display("[TB] FAIL rstmid_reach: got %0b expected 1", found); end
        reset = 1'b1;
        tick();
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_valid: got %0b expected 0", instr_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_busy: got %0b expected 0", busy); end
        n_cmp++; if (instr !== 19'h0) begin n_err++; $display("[TB] FAIL rstmid_instr: got %0h expected 0", instr); end
        n_cmp++; if (prog_done !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_done: got %0b expected 0", prog_done); end
        reset = 1'b0;
        clear_obs();
        cpu_ready = 1'b1;
        went_busy = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (busy) went_busy = 1'b1;
        end
        n_cmp++; if (went_busy !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_pending: got busy %0b expected 0", went_busy); end
        n_cmp++; if (got_done.size() !== 0) begin n_err++; $display("[TB] FAIL rstmid_no_done: got %0d expected 0", got_done.size()); end
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 20; it++) begin
            int c;
            bit ok;
            logic prev_v, prev_r;
            logic [18:0] prev_i;
            clear_obs();
            c = $urandom_range(0, 3);
            rom[c][0] = END_WORD_DEF;
            for (int a = 1; a < 8; a++) begin
                rom[c][a] = ($urandom_range(0, 5) == 0) ? END_WORD_DEF : rand_word();
            end
            model_append(c);
            cpu_ready = 1'b1;
            coin_req = 4'(1 << c);
            tick();
            coin_req = '0;
            ok = 1'b0;
            prev_v = 1'b0;
            prev_r = 1'b1;
            prev_i = '0;
            for (int k = 0; k < 200; k++) begin
                if (prev_v && !prev_r) begin
                    n_cmp++; if (instr_valid !== 1'b1 || instr !== prev_i) begin n_err++; $display("[TB] FAIL rand_stall: got %0b/%0h expected 1/%0h", instr_valid, instr, prev_i); end
                end
                if (got_done.size() >= 1) begin
                    ok = 1'b1;
                    break;
                end
                cpu_ready = ($urandom_range(0, 2) != 0);
                prev_v = instr_valid;
                prev_r = cpu_ready;
                prev_i = instr;
                tick();
            end
            cpu_ready = 1'b1;
            n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL rand_timeout%0d: got %0d dones expected 1", it, got_done.size()); end
            if (ok) begin
                n_cmp++; if (got_done[0] !== c) begin n_err++; $display("[TB] FAIL rand_coin%0d: got %0d expected %0d", it, got_done[0], c); end
            end
            n_cmp++; if (got_w.size() !== exp_w.size()) begin n_err++; $display("[TB] FAIL rand_count%0d: got %0d expected %0d", it, got_w.size(), exp_w.size()); end
            for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
                n_cmp++; if (got_w[k] !== exp_w[k]) begin n_err++; $display("[TB] FAIL rand_word%0d_%0d: got %0h expected %0h", it, k, got_w[k], exp_w[k]); end
            end
            tick();
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        coin_req = '0;
        cpu_ready = 1'b1;
        addr0_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int a = 0; a < 8; a++) rom[c][a] = END_WORD_DEF;
        end
        $display("[TB] starting coin_seq_ctrl bench");
        test_reset();
        test_single_program();
        test_backpressure();
        test_arbitration();
        test_overflow();
        test_no_end();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
